// File: rtl/bcd_frame_counter_display.sv
// bcd_frame_counter_display: N-digit decimal frame counter with an on-screen
// 7-segment renderer, running beside the VGA timing core on the pixel clock.
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zero digits
// (the least-significant digit is always drawn).
module bcd_frame_counter_display #(
  parameter int         NUM_DIGITS      = 4,
  parameter int         FRAMES_PER_STEP = 20,
  parameter int         DIGIT_W_LOG2    = 4,
  parameter int         GAP             = 4,
  parameter int         SEG_T           = 3,
  parameter logic [5:0] FG_COLOR        = 6'b111111,
  parameter logic [5:0] BG_COLOR        = 6'b010101
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [10:0]             x_px,
  input  logic [9:0]              y_px,
  input  logic [10:0]             x_origin,
  input  logic [9:0]              y_origin,
  input  logic                    enable,
  output logic [5:0]              color_px,
  output logic [4*NUM_DIGITS-1:0] count_bcd,
  output logic                    wrap
);

  localparam int D      = 2 ** DIGIT_W_LOG2;
  localparam int H      = 2 * D;
  localparam int W      = D - GAP;
  localparam int DIV_W  = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int CELL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAMES_PER_STEP - 1);
  localparam logic [11:0]      BOX_W    = 12'(NUM_DIGITS * D);
  localparam logic [11:0]      BOX_H    = 12'(H);

  // Counter state
  logic                    start, tick, step, carry;
  logic [3:0]              dig;
  logic                    start_d, start_q;
  logic [DIV_W-1:0]        div_d, div_q;
  logic [4*NUM_DIGITS-1:0] count_d, count_q;
  logic                    wrap_d, wrap_q;

  // Render pipeline state
  logic [11:0]             dx, dy;
  logic                    in_box_d, in_box_q;
  logic [CELL_W-1:0]       cell_d, cell_q;
  logic [DIGIT_W_LOG2-1:0] u_d, u_q;
  logic [DIGIT_W_LOG2:0]   v_d, v_q;
  logic [3:0]              digit;
  logic                    blank, lit;
  logic [6:0]              mask, seg;
  int                      u_i, v_i;
  logic [5:0]              color_d, color_q;
`ifdef LEADING_ZERO_BLANK_EN
  logic                    run_zero;
  logic [NUM_DIGITS-1:0]   lead_zero;
`endif

  // Frame edge detect, frame divider and ripple-carry BCD increment.
  always_comb begin
    start   = (x_px == 11'd0) && (y_px == 10'd0);
    start_d = start;
    tick    = start & ~start_q;
    div_d   = div_q;
    count_d = count_q;
    wrap_d  = 1'b0;
    step    = 1'b0;
    carry   = 1'b1;
    dig     = 4'd0;
    if (tick && enable) begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
        step  = 1'b1;
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
    if (step) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        dig = count_q[4*i +: 4];
        if (carry) begin
          if (dig == 4'd9) begin
            count_d[4*i +: 4] = 4'd0;
          end else begin
            count_d[4*i +: 4] = dig + 4'd1;
            carry             = 1'b0;
          end
        end
      end
      wrap_d = carry;
    end
  end

  // Counter registers; wrap is a single-cycle pulse on the all-nines rollover.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_q <= 1'b0;
      div_q   <= '0;
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      start_q <= start_d;
      div_q   <= div_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  // S1: box test in 12-bit arithmetic so a box hanging off-screen never wraps.
  always_comb begin
    dx       = {1'b0, x_px} - {1'b0, x_origin};
    dy       = {2'b00, y_px} - {2'b00, y_origin};
    in_box_d = ({1'b0, x_px} >= {1'b0, x_origin}) && (dx < BOX_W) &&
               ({2'b00, y_px} >= {2'b00, y_origin}) && (dy < BOX_H);
    cell_d   = dx[DIGIT_W_LOG2 +: CELL_W];
    u_d      = dx[DIGIT_W_LOG2-1:0];
    v_d      = dy[DIGIT_W_LOG2:0];
  end

  // S2: pick the digit for this cell, test the glyph segments, choose a colour.
  always_comb begin
    digit = 4'd0;
    blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    run_zero  = 1'b1;
    lead_zero = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run_zero     = run_zero && (count_q[4*i +: 4] == 4'd0);
      lead_zero[i] = run_zero;
    end
`endif
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (int'(cell_q) == NUM_DIGITS - 1 - i) begin
        digit = count_q[4*i +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        blank = lead_zero[i] && (i != 0);
`endif
      end
    end
    case (digit)
      4'd0:    mask = 7'b1111110;
      4'd1:    mask = 7'b0110000;
      4'd2:    mask = 7'b1101101;
      4'd3:    mask = 7'b1111001;
      4'd4:    mask = 7'b0110011;
      4'd5:    mask = 7'b1011011;
      4'd6:    mask = 7'b1011111;
      4'd7:    mask = 7'b1110000;
      4'd8:    mask = 7'b1111111;
      4'd9:    mask = 7'b1111011;
      default: mask = 7'b0000000;
    endcase
    u_i    = int'(u_q);
    v_i    = int'(v_q);
    seg[6] = (v_i < SEG_T);
    seg[5] = (u_i >= W - SEG_T) && (v_i < D);
    seg[4] = (u_i >= W - SEG_T) && (v_i >= D);
    seg[3] = (v_i >= H - SEG_T);
    seg[2] = (u_i < SEG_T) && (v_i >= D);
    seg[1] = (u_i < SEG_T) && (v_i < D);
    seg[0] = (v_i >= D - SEG_T) && (v_i < D);
    lit    = (u_i < W) && !blank && (|(seg & mask));
    if (!in_box_q) begin
      color_d = 6'b000000;
    end else if (lit) begin
      color_d = FG_COLOR;
    end else begin
      color_d = BG_COLOR;
    end
  end

  // Render pipeline registers: S1 geometry then S2 colour, two clocks total.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_box_q <= 1'b0;
      cell_q   <= '0;
      u_q      <= '0;
      v_q      <= '0;
      color_q  <= 6'b000000;
    end else begin
      in_box_q <= in_box_d;
      cell_q   <= cell_d;
      u_q      <= u_d;
      v_q      <= v_d;
      color_q  <= color_d;
    end
  end

  assign color_px  = color_q;
  assign count_bcd = count_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_bcd_frame_counter_display.sv
// Directed bench for bcd_frame_counter_display: counting, hold, wrap,
// render geometry, pipeline latency and asynchronous reset.
module tb_bcd_frame_counter_display;

   localparam logic [5:0] FG  = 6'b111111;
   localparam logic [5:0] BG  = 6'b010101;
   localparam logic [5:0] OFF = 6'b000000;
`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [5:0] LZ = BG;
`else
   localparam logic [5:0] LZ = FG;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [10:0] x_px, fx_px;
   logic [9:0]  y_px, fy_px;
   logic [10:0] x_origin;
   logic [9:0]  y_origin;
   logic        enable, f_enable;
   logic [5:0]  color_px, f_color_px;
   logic [15:0] count_bcd, f_count_bcd;
   logic        wrap, f_wrap;

   int checks = 0;
   int errors = 0;

   // Default build under test
   bcd_frame_counter_display dut (
      .clk(clk), .reset(reset), .x_px(x_px), .y_px(y_px),
      .x_origin(x_origin), .y_origin(y_origin), .enable(enable),
      .color_px(color_px), .count_bcd(count_bcd), .wrap(wrap)
   );

   // One-frame-per-step instance used to reach 9999 quickly
   bcd_frame_counter_display #(.FRAMES_PER_STEP(1)) dut_fast (
      .clk(clk), .reset(reset), .x_px(fx_px), .y_px(fy_px),
      .x_origin(x_origin), .y_origin(y_origin), .enable(f_enable),
      .color_px(f_color_px), .count_bcd(f_count_bcd), .wrap(f_wrap)
   );

   // Free-running pixel clock
   always #5 clk = ~clk;

   // Safety net so the run always ends
   initial begin
      #5000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [10:0] x, input logic [9:0] y);
      x_px = x;
      y_px = y;
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(11'd0, 10'd0);
         step();
         applyStimulus(11'd1, 10'd0);
         step();
      end
   endtask

   task automatic fastFrames(input int n);
      for (int i = 0; i < n; i++) begin
         fx_px = 11'd0; fy_px = 10'd0;
         step();
         fx_px = 11'd1; fy_px = 10'd0;
         step();
      end
   endtask

   task automatic pixelCheck(input string tag, input logic [10:0] x, input logic [9:0] y, input logic [5:0] expected);
      applyStimulus(x, y);
      step();
      step();
      checkOutput(tag, {26'd0, color_px}, {26'd0, expected});
   endtask

   // Linear directed sequence
   initial begin
      reset = 1'b1;
      enable = 1'b1; f_enable = 1'b1;
      x_origin = 11'd100; y_origin = 10'd100;
      applyStimulus(11'd1, 10'd0);
      fx_px = 11'd1; fy_px = 10'd0;
      step();
      step();
      checkOutput("rst_count", {16'd0, count_bcd}, 32'h0);
      checkOutput("rst_wrap", {31'd0, wrap}, 32'h0);
      checkOutput("rst_color", {26'd0, color_px}, 32'h0);
      checkOutput("rst_fast_count", {16'd0, f_count_bcd}, 32'h0);
      checkOutput("rst_fast_wrap", {31'd0, f_wrap}, 32'h0);
      checkOutput("rst_fast_color", {26'd0, f_color_px}, 32'h0);
      reset = 1'b0;

      // Origin held for five clocks counts as one tick
      applyStimulus(11'd0, 10'd0);
      repeat (5) step();
      applyStimulus(11'd1, 10'd0);
      step();
      checkOutput("hold_one_tick", {16'd0, count_bcd}, 32'h0);
      frames(18);
      checkOutput("tick19_no_step", {16'd0, count_bcd}, 32'h0);
      frames(1);
      checkOutput("tick20_step", {16'd0, count_bcd}, 32'h0001);

      // Disabled counting freezes count and divider
      enable = 1'b0;
      frames(40);
      checkOutput("disabled_hold", {16'd0, count_bcd}, 32'h0001);
      enable = 1'b1;
      frames(19);
      checkOutput("div_held_19", {16'd0, count_bcd}, 32'h0001);
      frames(1);
      checkOutput("div_held_20", {16'd0, count_bcd}, 32'h0002);
      frames(120);
      checkOutput("count_0008", {16'd0, count_bcd}, 32'h0008);

      // Render geometry with count 0008
      pixelCheck("px_149_114_f", 11'd149, 10'd114, FG);
      pixelCheck("px_156_114_g", 11'd156, 10'd114, FG);
      pixelCheck("px_150_116_e", 11'd150, 10'd116, FG);
      pixelCheck("px_99_100_left", 11'd99, 10'd100, OFF);
      pixelCheck("px_164_100_right", 11'd164, 10'd100, OFF);
      pixelCheck("px_100_100_ms_a", 11'd100, 10'd100, LZ);
      pixelCheck("px_111_100_edge", 11'd111, 10'd100, LZ);
      pixelCheck("px_112_100_gap", 11'd112, 10'd100, BG);
      pixelCheck("px_120_131_d", 11'd120, 10'd131, LZ);
      pixelCheck("px_120_132_below", 11'd120, 10'd132, OFF);
      pixelCheck("px_136_110_hole", 11'd136, 10'd110, BG);
      pixelCheck("px_148_100_a", 11'd148, 10'd100, FG);

      // Back-to-back pixels: exactly two clocks of latency
      applyStimulus(11'd99, 10'd100);
      step();
      applyStimulus(11'd149, 10'd114);
      step();
      checkOutput("lat_first", {26'd0, color_px}, {26'd0, OFF});
      step();
      checkOutput("lat_second", {26'd0, color_px}, {26'd0, FG});

      // Step forced mid-stream: earlier pixel sees 8, later pixel sees 9
      frames(19);
      checkOutput("pre_mid_count", {16'd0, count_bcd}, 32'h0008);
      applyStimulus(11'd150, 10'd116);
      step();
      applyStimulus(11'd0, 10'd0);
      step();
      checkOutput("mid_old_pixel", {26'd0, color_px}, {26'd0, FG});
      checkOutput("mid_count_9", {16'd0, count_bcd}, 32'h0009);
      applyStimulus(11'd150, 10'd116);
      step();
      checkOutput("mid_origin_px", {26'd0, color_px}, {26'd0, OFF});
      step();
      checkOutput("mid_new_pixel", {26'd0, color_px}, {26'd0, BG});
      checkOutput("mid_no_wrap", {31'd0, wrap}, 32'h0);
      applyStimulus(11'd1, 10'd0);
      step();

      // Asynchronous reset in the middle of a frame at count 0042
      frames(660);
      checkOutput("count_0042", {16'd0, count_bcd}, 32'h0042);
      applyStimulus(11'd149, 10'd114);
      step();
      step();
      checkOutput("pre_reset_px", {26'd0, color_px}, {26'd0, FG});
      #2 reset = 1'b1;
      #1;
      checkOutput("async_rst_count", {16'd0, count_bcd}, 32'h0);
      checkOutput("async_rst_wrap", {31'd0, wrap}, 32'h0);
      checkOutput("async_rst_color", {26'd0, color_px}, 32'h0);
      step();
      step();
      reset = 1'b0;
      applyStimulus(11'd1, 10'd0);
      step();
      frames(1);
      checkOutput("post_rst_tick1", {16'd0, count_bcd}, 32'h0);
      frames(19);
      checkOutput("post_rst_tick20", {16'd0, count_bcd}, 32'h0001);

      // Wrap from 9999 on the fast instance
      fastFrames(9999);
      checkOutput("fast_9999", {16'd0, f_count_bcd}, 32'h9999);
      checkOutput("fast_pre_wrap", {31'd0, f_wrap}, 32'h0);
      fx_px = 11'd0; fy_px = 10'd0;
      step();
      checkOutput("fast_wrap_count", {16'd0, f_count_bcd}, 32'h0000);
      checkOutput("fast_wrap_pulse", {31'd0, f_wrap}, 32'h1);
      fx_px = 11'd1; fy_px = 10'd0;
      step();
      checkOutput("fast_wrap_end", {31'd0, f_wrap}, 32'h0);
      checkOutput("fast_after_count", {16'd0, f_count_bcd}, 32'h0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
